dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port 64-bit data memory between two requesters: port 0 = pipeline MEM stage,
//  port 1 = debug/dump master. Sits between both masters and the data memory's
//  mem_read/mem_write/address/write_data/read_data pins. Grants one word access per cycle,
//  round-robin, and returns a tagged response one cycle later. Misaligned/out-of-range -> error.
// PARAMETERS
//  DEPTH   256  memory words (word index = addr[63:3]); index >= DEPTH is out of range
//  DATA_W  64   data width
//  ADDR_W  64   byte address width
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  rst         in   1       asynchronous, active-low reset
//  req_valid   in   [2]     per-port request valid
//  req_ready   out  [2]     per-port grant (accept when valid & ready)
//  req_we      in   [2]     1 = write, 0 = read
//  req_addr    in   [2][ADDR_W] byte address
//  req_wdata   in   [2][DATA_W] write data
//  rsp_valid   out  [2]     response strobe, one cycle, exactly one per accepted request
//  rsp_err     out  1       response error flag (qualified by rsp_valid)
//  rsp_rdata   out  DATA_W  read data (qualified by rsp_valid & ~rsp_err & read)
//  mem_address out  ADDR_W  to memory, byte address
//  mem_wdata   out  DATA_W  to memory write_data
//  mem_read    out  1       to memory read enable
//  mem_write   out  1       to memory write enable
//  mem_rdata   in   DATA_W  from memory read_data (registered in memory, 1-cycle latency)
// BEHAVIOUR
//  - Reset (rst=0, async): rsp_valid=0, rsp_err=0, rr_ptr=0 (port 0 favoured), in-flight
//    tag cleared; mem_read/mem_write=0 while rst=0. In-flight response is dropped, never emitted.
//  - Arbitration (comb, cycle T): one valid -> it wins; both valid -> port != rr_ptr... i.e.
//    winner = rr_ptr if req_valid[rr_ptr], else other. req_ready is 1 only for the winner.
//    On accept rr_ptr <= ~winner. No accept -> rr_ptr holds.
//  - Memory drive (comb, cycle T): mem_address/mem_wdata = winner's; mem_read = accept & ~we &
//    ok; mem_write = accept & we & ok; ok = (addr[2:0]==0) & (addr[63:3] < DEPTH).
//    All mem_* enables 0 when no accept. Address/data don't-care when enables 0.
//  - Response (cycle T+1): registered tag {valid, port, we, err}. rsp_valid[port]=1 for one
//    cycle; rsp_err=~ok; rsp_rdata = mem_rdata when read & ~err, else 0. Writes ack with rdata 0.
//  - Throughput: one accept per cycle, fully pipelined, no stall states; back-to-back from the
//    same port allowed when other port idle.
//  - Error request: accepted, no memory access, rsp_err=1 at T+1.
//  - Write at T, read same word at T+1: read returns new data (memory write lands at end of T).
//  - Requester must hold valid/we/addr/wdata stable until accepted; dropping valid un-accepted
//    is allowed (no accept recorded, rr_ptr unchanged).
//  - State machine: 2 states on tag: IDLE (no response pending), RESP (response due this cycle);
//    IDLE->RESP on accept, RESP->RESP on accept, RESP->IDLE otherwise.
// STRUCTURE
//  - Package dmem_arb_pkg: typedef struct {we, addr, wdata} dmem_req_t; enum {PORT_CPU=0,
//    PORT_DBG=1}; struct rsp tag {valid, port, we, err}; localparam WORD_SHIFT=3.
//  - Sub-module rr_arb2: 2-way round-robin arbiter (req[2], accept strobe -> gnt[2], ptr reg).
//  - Top: rr_arb2, ok-check comb, request mux, response tag register.
// TESTING
//  1 Reset: hold rst=0 with both req_valid=1 -> mem_read=mem_write=0, rsp_valid=00; release,
//    first grant goes to port 0.
//  2 Port0 write addr 0x10 data 0xDEAD_BEEF, next cycle port0 read 0x10 -> rsp_valid[0] at T+1
//    of read with rsp_rdata=0xDEAD_BEEF, rsp_err=0.
//  3 Both ports read continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each port gets
//    3 responses, each exactly one cycle after its accept.
//  4 Port1 read addr 0x13 (misaligned) and addr 0x800 (index 256) -> no mem_read pulse,
//    rsp_valid[1]=1 with rsp_err=1, rsp_rdata=0.
//  5 Accept read, assert rst=0 mid-cycle before T+1 -> rsp_valid stays 0, no stale response after
//    release; rr_ptr back to 0.
//  6 Port1 alone, 4 back-to-back writes 0x0,0x8,0x10,0x18 -> 4 mem_write pulses, 4 acks,
//    req_ready[1]=1 every cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and helpers for the two-port data memory arbiter
package dmem_arb_pkg;

    localparam int DATA_W     = 64;
    localparam int ADDR_W     = 64;
    localparam int WORD_SHIFT = 3;
    localparam int IDX_W      = ADDR_W - WORD_SHIFT;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } tag_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  we;
        logic  err;
    } rsp_tag_t;

    // Word aligned and inside the memory; anything else is answered with an error.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return (addr[WORD_SHIFT-1:0] == '0) && (addr[ADDR_W-1:WORD_SHIFT] < IDX_W'(depth));
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side bus shared by the pipeline and debug masters
interface dmem_arb_if;
    import dmem_arb_pkg::*;

    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             rsp_valid;
    logic                   rsp_err;
    logic [DATA_W-1:0]      rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin arbiter with a registered priority pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       winner
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        winner = req[ptr_q] ? ptr_q : ~ptr_q;
        gnt    = 2'b00;
        if (|req) begin
            gnt[winner] = 1'b1;
        end
    end

    // Kept apart from the grant logic so accept (derived from gnt) does not loop back.
    always_comb begin
        ptr_d = accept ? ~winner : ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between pipeline and debug masters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arb_if.slave         bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0] gnt;
    logic       winner;
    logic       accept;
    logic       ok;
    logic       resp_due;
    dmem_req_t  sel;
    rsp_tag_t   tag_q;
    rsp_tag_t   tag_d;
    tag_state_e state_q;
    tag_state_e state_d;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .accept (accept),
        .gnt    (gnt),
        .winner (winner)
    );

    // Grants and memory strobes are forced low while reset is held, even with valid requests.
    always_comb begin
        sel.we        = bus.req_we[winner];
        sel.addr      = bus.req_addr[winner];
        sel.wdata     = bus.req_wdata[winner];
        ok            = addr_ok(sel.addr, DEPTH);
        bus.req_ready = gnt & {2{rst}};
        accept        = |(bus.req_valid & bus.req_ready);
        mem_address   = sel.addr;
        mem_wdata     = sel.wdata;
        mem_read      = accept & ~sel.we & ok;
        mem_write     = accept & sel.we & ok;
        tag_d.valid   = accept;
        tag_d.port    = port_e'(winner);
        tag_d.we      = sel.we;
        tag_d.err     = ~ok;
        state_d       = accept ? ST_RESP : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    // Memory read data arrives one cycle after the strobe, aligned with the registered tag.
    always_comb begin
        resp_due      = (state_q == ST_RESP) & tag_q.valid;
        bus.rsp_valid = 2'b00;
        if (resp_due) begin
            bus.rsp_valid[tag_q.port] = 1'b1;
        end
        bus.rsp_err   = resp_due & tag_q.err;
        bus.rsp_rdata = (resp_due & ~tag_q.we & ~tag_q.err) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DEPTH = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_read;
    logic              mem_write;

    dmem_arb_if ifc();

    dmem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (ifc),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory seen by the arbiter: registered read, write lands at the clock edge.
    logic [63:0] env_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_write) env_mem[mem_address[10:3]] <= mem_wdata;
        if (mem_read)  mem_rdata <= env_mem[mem_address[10:3]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word array, last-winner pointer, one pending response.
    logic [63:0] ref_mem [DEPTH];
    bit          ref_ptr;
    bit          due, due_port, due_err;
    logic [63:0] due_rdata;
    bit          pend_acc, pend_port, pend_err, pend_wr;
    logic [63:0] pend_rdata, pend_wdata;
    int          pend_idx;
    bit          m_any, m_w, m_we, m_ok;
    logic [63:0] m_addr;
    int          m_idx;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req_ready", 64'(ifc.req_ready), 64'd0);
            chk("rst_mem_en", 64'({mem_read, mem_write}), 64'd0);
            chk("rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
            pend_acc = 1'b0;
        end else begin
            chk("rsp_valid", 64'(ifc.rsp_valid), due ? 64'(2'b01 << due_port) : 64'd0);
            if (due) begin
                chk("rsp_err", 64'(ifc.rsp_err), 64'(due_err));
                chk("rsp_rdata", ifc.rsp_rdata, due_rdata);
            end
            m_any  = |ifc.req_valid;
            m_w    = (ifc.req_valid == 2'b11) ? ref_ptr : ifc.req_valid[1];
            m_addr = ifc.req_addr[m_w];
            m_we   = ifc.req_we[m_w];
            m_ok   = (m_addr % 8 == 0) && (m_addr / 8 < 64'(DEPTH));
            m_idx  = m_ok ? int'(m_addr / 8) : 0;
            chk("req_ready", 64'(ifc.req_ready), m_any ? 64'(2'b01 << m_w) : 64'd0);
            chk("mem_read", 64'(mem_read), 64'(m_any && !m_we && m_ok));
            chk("mem_write", 64'(mem_write), 64'(m_any && m_we && m_ok));
            if (m_any && m_ok) begin
                chk("mem_address", mem_address, m_addr);
                if (m_we) chk("mem_wdata", mem_wdata, ifc.req_wdata[m_w]);
            end
            pend_acc   = m_any;
            pend_port  = m_w;
            pend_err   = !m_ok;
            pend_wr    = m_we && m_ok;
            pend_idx   = m_idx;
            pend_wdata = ifc.req_wdata[m_w];
            pend_rdata = (!m_we && m_ok) ? ref_mem[m_idx] : 64'd0;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            due     = 1'b0;
            ref_ptr = 1'b0;
        end else begin
            due       = pend_acc;
            due_port  = pend_port;
            due_err   = pend_err;
            due_rdata = pend_rdata;
            if (pend_acc) ref_ptr = !pend_port;
            if (pend_acc && pend_wr) ref_mem[pend_idx] = pend_wdata;
            pend_acc = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.req_valid = 2'b00;
    endtask

    task automatic drive(input int p, input bit we, input logic [63:0] a, input logic [63:0] d);
        ifc.req_valid[p] = 1'b1;
        ifc.req_we[p]    = we;
        ifc.req_addr[p]  = a;
        ifc.req_wdata[p] = d;
    endtask

    task automatic new_req(input int p);
        int          k;
        logic [63:0] a;
        k = $urandom_range(9);
        a = 64'($urandom_range(15)) << 3;
        if (k == 0) a = a | 64'($urandom_range(7, 1));
        else if (k == 1) a = 64'($urandom_range(2000, DEPTH)) << 3;
        else if (k == 2) a = {$urandom, $urandom} & ~64'd7;
        ifc.req_valid[p] = ($urandom_range(3) != 0);
        ifc.req_we[p]    = 1'($urandom_range(1));
        ifc.req_addr[p]  = a;
        ifc.req_wdata[p] = {$urandom, $urandom};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] v;
        logic [63:0] bad_addr [2];
        logic [1:0]  acc;
        int          n0, n1;

        ifc.req_valid = '0;
        ifc.req_we    = '0;
        ifc.req_addr  = '0;
        ifc.req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v = {$urandom, $urandom};
            env_mem[i] <= v;
            ref_mem[i] = v;
        end
        #1 rst = 1'b0;

        // Reset held with both masters requesting, then release into alternating grants.
        drive(0, 1'b0, 64'h40, 64'd0);
        drive(1, 1'b0, 64'h48, 64'd0);
        repeat (3) step();
        @(negedge clk);
        chk("t1_mem_en_in_rst", 64'({mem_read, mem_write}), 64'd0);
        chk("t1_rsp_in_rst", 64'(ifc.rsp_valid), 64'd0);
        step();
        rst = 1'b1;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t3_grant", 64'(ifc.req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            n0 += int'(ifc.rsp_valid[0]);
            n1 += int'(ifc.rsp_valid[1]);
            step();
        end
        idle();
        @(negedge clk);
        n0 += int'(ifc.rsp_valid[0]);
        n1 += int'(ifc.rsp_valid[1]);
        chk("t3_rsp_count_p0", 64'(n0), 64'd3);
        chk("t3_rsp_count_p1", 64'(n1), 64'd3);

        // Write then immediately read the same word.
        step();
        drive(0, 1'b1, 64'h10, 64'hDEAD_BEEF);
        step();
        drive(0, 1'b0, 64'h10, 64'd0);
        step();
        idle();
        @(negedge clk);
        chk("t2_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
        chk("t2_rsp_err", 64'(ifc.rsp_err), 64'd0);
        chk("t2_rsp_rdata", ifc.rsp_rdata, 64'hDEAD_BEEF);

        // Misaligned and out-of-range reads from the debug port.
        bad_addr[0] = 64'h13;
        bad_addr[1] = 64'h800;
        for (int i = 0; i < 2; i++) begin
            step();
            drive(1, 1'b0, bad_addr[i], 64'd0);
            @(negedge clk);
            chk("t4_ready", 64'(ifc.req_ready), 64'd2);
            chk("t4_no_mem_read", 64'(mem_read), 64'd0);
            step();
            idle();
            @(negedge clk);
            chk("t4_rsp_valid", 64'(ifc.rsp_valid), 64'd2);
            chk("t4_rsp_err", 64'(ifc.rsp_err), 64'd1);
            chk("t4_rsp_rdata", ifc.rsp_rdata, 64'd0);
        end

        // Reset lands between accept and response: the response must vanish.
        step();
        drive(1, 1'b0, 64'h20, 64'd0);
        @(negedge clk);
        chk("t5_ready", 64'(ifc.req_ready), 64'd2);
        #2 rst = 1'b0;
        idle();
        repeat (2) step();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_no_stale_rsp", 64'(ifc.rsp_valid), 64'd0);
        step();
        drive(0, 1'b0, 64'h28, 64'd0);
        drive(1, 1'b0, 64'h30, 64'd0);
        @(negedge clk);
        chk("t5_ptr_reset", 64'(ifc.req_ready), 64'd1);
        step();
        idle();

        // Debug port alone issues four back-to-back writes.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 64'(i * 8), {$urandom, $urandom});
            @(negedge clk);
            chk("t6_ready", 64'(ifc.req_ready), 64'd2);
            chk("t6_mem_write", 64'(mem_write), 64'd1);
            if (i > 0) chk("t6_ack", 64'(ifc.rsp_valid), 64'd2);
            step();
        end
        idle();
        @(negedge clk);
        chk("t6_last_ack", 64'(ifc.rsp_valid), 64'd2);
        step();

        // Random traffic, occasional drops of un-accepted requests and mid-cycle resets.
        acc = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (ifc.req_valid[p] && !acc[p]) begin
                    if ($urandom_range(9) == 0) ifc.req_valid[p] = 1'b0;
                end else begin
                    new_req(p);
                end
            end
            @(negedge clk);
            acc = ifc.req_valid & ifc.req_ready;
            if ($urandom_range(299) == 0) begin
                #2 rst = 1'b0;
                step();
                rst = 1'b1;
                acc = 2'b11;
            end else begin
                step();
            end
        end
        idle();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
